// File: rtl/iomem_pkg.sv
// Shared definitions for picosoc iomem peripherals: base address map,
// GPIO register offsets and the byte-strobe mask helper.
package iomem_pkg;

   localparam logic [7:0] IOMEM_BASE_CFG   = 8'h02;
   localparam logic [7:0] IOMEM_BASE_GPIO  = 8'h03;
   localparam logic [7:0] IOMEM_BASE_TIMER = 8'h04;

   typedef enum logic [2:0] {
      GPIO_OUT     = 3'd0,
      GPIO_OE      = 3'd1,
      GPIO_IN      = 3'd2,
      GPIO_RISE_EN = 3'd3,
      GPIO_FALL_EN = 3'd4,
      GPIO_PENDING = 3'd5,
      GPIO_OUT_SET = 3'd6,
      GPIO_OUT_CLR = 3'd7
   } gpio_reg_e;

   // Expands the four byte strobes into a 32-bit bit mask.
   function automatic logic [31:0] strb_mask(input logic [3:0] wstrb);
      logic [31:0] m;
      m = '0;
      for (int k = 0; k < 4; k++) begin
         if (wstrb[k]) m[8*k +: 8] = 8'hFF;
      end
      return m;
   endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser followed by a history flop; reports the
// synchronised level plus single-cycle rise/fall strobes per pin.
module gpio_sync_edge #(
   parameter int NPINS       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [NPINS-1:0] pin_in,
   output logic [NPINS-1:0] s,
   output logic [NPINS-1:0] rise,
   output logic [NPINS-1:0] fall
);

   logic [SYNC_STAGES-1:0][NPINS-1:0] sync_q, sync_d;
   logic [NPINS-1:0]                  prev_q, prev_d;

   always_comb begin
      sync_d[0] = pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      prev_d = sync_q[SYNC_STAGES-1];
   end

   // History resets to the same value as the synchroniser so no edge is
   // reported until a pad actually changes after reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~prev_q;
   assign fall = ~s & prev_q;

endmodule

// File: rtl/iomem_gpio_irq.sv
// GPIO peripheral on the picosoc iomem bus: output/enable registers with
// atomic set/clear, synchronised input readback and edge interrupts.
module iomem_gpio_irq
   import iomem_pkg::*;
#(
   parameter int               NPINS       = 8,
   parameter logic [7:0]       BASE_ADDR   = 8'h03,
   parameter int               SYNC_STAGES = 2,
   parameter logic [NPINS-1:0] RESET_OUT   = '0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             iomem_valid,
   output logic             iomem_ready,
   input  logic [3:0]       iomem_wstrb,
   input  logic [31:0]      iomem_addr,
   input  logic [31:0]      iomem_wdata,
   output logic [31:0]      iomem_rdata,
   input  logic [NPINS-1:0] gpio_in,
   output logic [NPINS-1:0] gpio_out,
   output logic [NPINS-1:0] gpio_oe,
   output logic             irq
);

   logic             ready_q, ready_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [NPINS-1:0] out_q, out_d;
   logic [NPINS-1:0] oe_q, oe_d;
   logic [NPINS-1:0] rise_en_q, rise_en_d;
   logic [NPINS-1:0] fall_en_q, fall_en_d;
   logic [NPINS-1:0] pend_q, pend_d;
   logic             irq_q, irq_d;

   logic             hit;
   gpio_reg_e        reg_sel;
   logic [31:0]      byte_mask, wr_word, rd_word;
   logic [NPINS-1:0] wr_bits, wr_keep, w1c_bits;
   logic [NPINS-1:0] s_in, rise, fall;
   logic             unused_bits;

   gpio_sync_edge #(
      .NPINS      (NPINS),
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .resetn(resetn),
      .pin_in(gpio_in),
      .s     (s_in),
      .rise  (rise),
      .fall  (fall)
   );

   // ready_q blocks a second hit so every acknowledge is exactly one cycle.
   assign hit       = iomem_valid & ~ready_q & (iomem_addr[31:24] == BASE_ADDR);
   assign reg_sel   = gpio_reg_e'(iomem_addr[4:2]);
   assign byte_mask = strb_mask(iomem_wstrb);
   assign wr_word   = iomem_wdata & byte_mask;
   assign wr_bits   = wr_word[NPINS-1:0];
   assign wr_keep   = byte_mask[NPINS-1:0];

   assign unused_bits = ^{iomem_addr[23:5], iomem_addr[1:0], wr_word, byte_mask};

   always_comb begin
      rd_word = '0;
      case (reg_sel)
         GPIO_OUT:     rd_word[NPINS-1:0] = out_q;
         GPIO_OE:      rd_word[NPINS-1:0] = oe_q;
         GPIO_IN:      rd_word[NPINS-1:0] = s_in;
         GPIO_RISE_EN: rd_word[NPINS-1:0] = rise_en_q;
         GPIO_FALL_EN: rd_word[NPINS-1:0] = fall_en_q;
         GPIO_PENDING: rd_word[NPINS-1:0] = pend_q;
         default:      rd_word = '0;
      endcase
   end

   always_comb begin
      ready_d   = hit;
      rdata_d   = rdata_q;
      out_d     = out_q;
      oe_d      = oe_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      w1c_bits  = '0;
      irq_d     = |pend_q;
      if (hit) begin
         rdata_d = rd_word;
         case (reg_sel)
            GPIO_OUT:     out_d     = (out_q & ~wr_keep) | wr_bits;
            GPIO_OE:      oe_d      = (oe_q & ~wr_keep) | wr_bits;
            GPIO_RISE_EN: rise_en_d = (rise_en_q & ~wr_keep) | wr_bits;
            GPIO_FALL_EN: fall_en_d = (fall_en_q & ~wr_keep) | wr_bits;
            GPIO_PENDING: w1c_bits  = wr_bits;
            GPIO_OUT_SET: out_d     = out_q | wr_bits;
            GPIO_OUT_CLR: out_d     = out_q & ~wr_bits;
            default:      ;
         endcase
      end
      // New edges are OR-ed in after the clear so a coincident edge survives.
      pend_d = (pend_q & ~w1c_bits) | (rise & rise_en_q) | (fall & fall_en_q);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ready_q   <= 1'b0;
         rdata_q   <= '0;
         out_q     <= RESET_OUT;
         oe_q      <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         pend_q    <= '0;
         irq_q     <= 1'b0;
      end else begin
         ready_q   <= ready_d;
         rdata_q   <= rdata_d;
         out_q     <= out_d;
         oe_q      <= oe_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         pend_q    <= pend_d;
         irq_q     <= irq_d;
      end
   end

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign gpio_out    = out_q;
   assign gpio_oe     = oe_q;
   assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_gpio_irq.sv
// Bench for iomem_gpio_irq: directed scenarios then random bus/pad traffic,
// every cycle compared against a cycle-level behavioural model.
module tb_iomem_gpio_irq;

   localparam int NPINS = 8;
   localparam int SYNC  = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic [7:0]  gpio_in;
   logic [7:0]  gpio_out;
   logic [7:0]  gpio_oe;
   logic        irq;

   int n_cmp  = 0;
   int n_fail = 0;

   // Model state as it should look just after each rising edge.
   logic [7:0]  m_out, m_oe, m_rise, m_fall, m_pend;
   logic        m_irq, m_ready;
   logic [31:0] m_rdata;
   logic [7:0]  samp[$];

   always #5 clk = ~clk;

   iomem_gpio_irq #(
      .NPINS      (NPINS),
      .BASE_ADDR  (8'h03),
      .SYNC_STAGES(SYNC),
      .RESET_OUT  (8'h00)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .iomem_valid(iomem_valid),
      .iomem_ready(iomem_ready),
      .iomem_wstrb(iomem_wstrb),
      .iomem_addr (iomem_addr),
      .iomem_wdata(iomem_wdata),
      .iomem_rdata(iomem_rdata),
      .gpio_in    (gpio_in),
      .gpio_out   (gpio_out),
      .gpio_oe    (gpio_oe),
      .irq        (irq)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_out   = 8'h00;
      m_oe    = 8'h00;
      m_rise  = 8'h00;
      m_fall  = 8'h00;
      m_pend  = 8'h00;
      m_irq   = 1'b0;
      m_ready = 1'b0;
      m_rdata = 32'h0;
      samp.delete();
      for (int i = 0; i < SYNC + 1; i++) samp.push_back(8'h00);
   endtask

   // The synchronised level is the pad value sampled SYNC-1 edges earlier.
   function automatic logic [31:0] model_read(input logic [2:0] off);
      logic [7:0] v;
      case (off)
         3'd0:    v = m_out;
         3'd1:    v = m_oe;
         3'd2:    v = samp[samp.size() - SYNC];
         3'd3:    v = m_rise;
         3'd4:    v = m_fall;
         3'd5:    v = m_pend;
         default: v = 8'h00;
      endcase
      return {24'h0, v};
   endfunction

   // Advance model and DUT by one clock edge, then compare visible state.
   task automatic cycle();
      logic [7:0]  s_pre, p_pre, new_edges, wb, keep, clr;
      logic [31:0] bm, wd;
      logic        hit, irq_next;
      int          n;
      n         = samp.size();
      s_pre     = samp[n - SYNC];
      p_pre     = samp[n - SYNC - 1];
      new_edges = ((s_pre & ~p_pre) & m_rise) | ((~s_pre & p_pre) & m_fall);
      hit       = iomem_valid && !m_ready && (iomem_addr[31:24] == 8'h03);
      bm        = 32'h0;
      for (int k = 0; k < 4; k++) if (iomem_wstrb[k]) bm[8*k +: 8] = 8'hFF;
      wd        = iomem_wdata & bm;
      wb        = wd[7:0];
      keep      = bm[7:0];
      clr       = 8'h00;
      irq_next  = (m_pend != 8'h00);
      if (hit) begin
         m_rdata = model_read(iomem_addr[4:2]);
         case (iomem_addr[4:2])
            3'd0: m_out  = (m_out & ~keep) | wb;
            3'd1: m_oe   = (m_oe & ~keep) | wb;
            3'd3: m_rise = (m_rise & ~keep) | wb;
            3'd4: m_fall = (m_fall & ~keep) | wb;
            3'd5: clr    = wb;
            3'd6: m_out  = m_out | wb;
            3'd7: m_out  = m_out & ~wb;
            default: ;
         endcase
      end
      m_pend  = (m_pend & ~clr) | new_edges;
      m_irq   = irq_next;
      m_ready = hit;
      samp.push_back(gpio_in);
      if (samp.size() > 8) void'(samp.pop_front());
      @(posedge clk);
      #1;
      checkOutput("ready",    32'(iomem_ready), 32'(m_ready));
      checkOutput("rdata",    iomem_rdata,      m_rdata);
      checkOutput("irq",      32'(irq),         32'(m_irq));
      checkOutput("gpio_out", 32'(gpio_out),    32'(m_out));
      checkOutput("gpio_oe",  32'(gpio_oe),     32'(m_oe));
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] wstrb,
                                input logic [31:0] wdata, output logic [31:0] rd);
      iomem_valid = 1'b1;
      iomem_addr  = addr;
      iomem_wstrb = wstrb;
      iomem_wdata = wdata;
      cycle();
      rd = iomem_rdata;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      cycle();
   endtask

   localparam logic [31:0] A_OUT  = 32'h0300_0000;
   localparam logic [31:0] A_OE   = 32'h0300_0004;
   localparam logic [31:0] A_IN   = 32'h0300_0008;
   localparam logic [31:0] A_RISE = 32'h0300_000C;
   localparam logic [31:0] A_FALL = 32'h0300_0010;
   localparam logic [31:0] A_PEND = 32'h0300_0014;
   localparam logic [31:0] A_SET  = 32'h0300_0018;
   localparam logic [31:0] A_CLR  = 32'h0300_001C;

   initial begin
      logic [31:0] rd;
      logic [7:0]  base;
      logic [2:0]  off;
      int          op;
      int          len;

      resetn      = 1'b1;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      iomem_addr  = 32'h0;
      iomem_wdata = 32'h0;
      gpio_in     = 8'h00;
      model_reset();
      #2 resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      checkOutput("rst_ready", 32'(iomem_ready), 32'h0);
      checkOutput("rst_rdata", iomem_rdata, 32'h0);
      checkOutput("rst_irq",   32'(irq), 32'h0);
      checkOutput("rst_out",   32'(gpio_out), 32'h0);
      checkOutput("rst_oe",    32'(gpio_oe), 32'h0);

      // Reset pulsed while a read is being acknowledged.
      applyStimulus(A_OE, 4'hF, 32'h0000_005A, rd);
      iomem_valid = 1'b1;
      iomem_addr  = A_OE;
      iomem_wstrb = 4'h0;
      cycle();
      resetn = 1'b0;
      #1;
      checkOutput("midrd_ready", 32'(iomem_ready), 32'h0);
      checkOutput("midrd_rdata", iomem_rdata, 32'h0);
      checkOutput("midrd_irq",   32'(irq), 32'h0);
      iomem_valid = 1'b0;
      model_reset();
      @(posedge clk);
      #1 resetn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(32'h0300_0000 | (i << 2), 4'h0, 32'h0, rd);
         checkOutput($sformatf("rst_reg%0d", i), rd, 32'h0);
      end

      // Low-byte write with junk in the upper bytes.
      iomem_valid = 1'b1;
      iomem_addr  = A_OUT;
      iomem_wstrb = 4'b0001;
      iomem_wdata = 32'hFFFF_FFA5;
      cycle();
      checkOutput("ack_a5", 32'(iomem_ready), 32'h1);
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      cycle();
      checkOutput("ack_width", 32'(iomem_ready), 32'h0);
      checkOutput("out_a5", 32'(gpio_out), 32'hA5);
      applyStimulus(A_OUT, 4'h0, 32'h0, rd);
      checkOutput("rd_out_a5", rd, 32'h0000_00A5);

      applyStimulus(A_OUT, 4'hF, 32'h0000_00F0, rd);
      applyStimulus(A_SET, 4'hF, 32'h0000_0003, rd);
      applyStimulus(A_CLR, 4'hF, 32'h0000_0010, rd);
      checkOutput("out_e3", 32'(gpio_out), 32'hE3);
      applyStimulus(A_SET, 4'h0, 32'h0, rd);
      checkOutput("rd_set_zero", rd, 32'h0);
      applyStimulus(A_CLR, 4'h0, 32'h0, rd);
      checkOutput("rd_clr_zero", rd, 32'h0);

      // Rising edge on pin 0: PENDING after 3 edges, irq after 4.
      applyStimulus(A_RISE, 4'hF, 32'h0000_0001, rd);
      gpio_in = 8'h01;
      repeat (3) cycle();
      checkOutput("irq_edge3", 32'(irq), 32'h0);
      cycle();
      checkOutput("irq_edge4", 32'(irq), 32'h1);
      applyStimulus(A_PEND, 4'h0, 32'h0, rd);
      checkOutput("pend_rise0", rd, 32'h0000_0001);
      applyStimulus(A_PEND, 4'hF, 32'h0000_0001, rd);
      checkOutput("irq_w1c", 32'(irq), 32'h0);

      // Fall on pin 1 lands on the same edge as a W1C of that bit.
      applyStimulus(A_FALL, 4'hF, 32'h0000_0002, rd);
      gpio_in = 8'h03;
      repeat (4) cycle();
      gpio_in = 8'h01;
      cycle();
      cycle();
      iomem_valid = 1'b1;
      iomem_addr  = A_PEND;
      iomem_wstrb = 4'hF;
      iomem_wdata = 32'h0000_0002;
      cycle();
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      cycle();
      applyStimulus(A_PEND, 4'h0, 32'h0, rd);
      checkOutput("pend_set_wins", rd, 32'h0000_0002);
      applyStimulus(A_IN, 4'h0, 32'h0, rd);
      checkOutput("rd_in", rd, 32'h0000_0001);
      applyStimulus(A_PEND, 4'hF, 32'h0000_0002, rd);

      // Foreign base address and strobe-less write must change nothing.
      applyStimulus(32'h0400_0000, 4'hF, 32'h0000_00FF, rd);
      checkOutput("foreign_noack", 32'(iomem_ready), 32'h0);
      applyStimulus(A_OUT, 4'h0, 32'h0, rd);
      checkOutput("foreign_out", rd, 32'h0000_00E3);
      applyStimulus(A_OE, 4'h0, 32'h0000_00FF, rd);
      checkOutput("oe_nostrb", 32'(gpio_oe), 32'h0);

      for (int it = 0; it < 400; it++) begin
         op = $urandom_range(0, 9);
         if (op < 3) begin
            gpio_in = 8'($urandom);
            repeat ($urandom_range(1, 4)) cycle();
         end else begin
            base        = ($urandom_range(0, 7) == 0) ? 8'h04 : 8'h03;
            off         = 3'($urandom_range(0, 7));
            iomem_valid = 1'b1;
            iomem_addr  = {base, 19'($urandom), off, 2'($urandom)};
            iomem_wstrb = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            iomem_wdata = $urandom;
            len         = $urandom_range(1, 2);
            repeat (len) cycle();
            iomem_valid = 1'b0;
            iomem_wstrb = 4'h0;
            cycle();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
